// File: rtl/shader_raster_pkg.sv
package shader_raster_pkg;

  typedef enum logic {
    TIME_BOUNCE = 1'b0,
    TIME_WRAP   = 1'b1
  } time_mode_e;

  localparam int unsigned VGA_WIDTH  = 640;
  localparam int unsigned VGA_HEIGHT = 480;
  localparam int unsigned VGA_HFRONT = 16;
  localparam int unsigned VGA_HSYNC  = 96;
  localparam int unsigned VGA_HBACK  = 48;
  localparam int unsigned VGA_VFRONT = 10;
  localparam int unsigned VGA_VSYNC  = 2;
  localparam int unsigned VGA_VBACK  = 33;

  typedef struct packed {
    logic [31:0] value;
    logic        down;
  } time_next_t;

  // Values are zero-extended into 32 bits, so the 33-bit sum covers any TIME_W <= 31.
  function automatic time_next_t time_next(input logic [31:0] cur,
                                           input logic        down,
                                           input time_mode_e  mode,
                                           input logic [2:0]  step,
                                           input logic [31:0] tmax);
    time_next_t r;
    logic [32:0] sum;
    r.value = cur;
    r.down  = down;
    sum     = {1'b0, cur} + {30'd0, step};
    if (mode == TIME_WRAP) begin
      r.value = sum[31:0] & tmax;
      r.down  = 1'b0;
    end else if (step != '0) begin
      if (!down) begin
        if (sum >= {1'b0, tmax}) begin
          r.value = tmax;
          r.down  = 1'b1;
        end else begin
          r.value = sum[31:0];
        end
      end else begin
        if ({29'd0, step} >= cur) begin
          r.value = '0;
          r.down  = 1'b0;
        end else begin
          r.value = cur - {29'd0, step};
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/shader_raster_axis.sv
module raster_axis #(
  parameter int unsigned TOTAL      = 800,
  parameter int unsigned RESOLUTION = 640,
  parameter int unsigned FRONT      = 16,
  parameter int unsigned SYNC       = 96,
  parameter int unsigned RESET_VAL  = 0,
  parameter logic        SYNC_POL   = 1'b0
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      enable_i,
  output logic [$clog2(TOTAL)-1:0]  cnt_o,
  output logic                      sync_o,
  output logic                      blank_o,
  output logic                      last_o
);

  localparam int unsigned W = $clog2(TOTAL);
  localparam logic [W-1:0] LAST    = W'(TOTAL - 1);
  localparam logic [W-1:0] RES     = W'(RESOLUTION);
  localparam logic [W-1:0] SYNC_LO = W'(RESOLUTION + FRONT);
  localparam logic [W-1:0] SYNC_HI = W'(RESOLUTION + FRONT + SYNC - 1);
  localparam logic [W-1:0] RST     = W'(RESET_VAL);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= RST;
    end else if (enable_i) begin
      cnt_q <= (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    end
  end

  always_comb begin
    cnt_o   = cnt_q;
    sync_o  = (cnt_q >= SYNC_LO && cnt_q <= SYNC_HI) ? SYNC_POL : ~SYNC_POL;
    blank_o = (cnt_q >= RES);
    last_o  = (cnt_q == LAST);
  end

endmodule

// File: rtl/shader_raster.sv
module shader_raster
  import shader_raster_pkg::*;
#(
  parameter int unsigned WIDTH     = VGA_WIDTH,
  parameter int unsigned HEIGHT    = VGA_HEIGHT,
  parameter int unsigned HFRONT    = VGA_HFRONT,
  parameter int unsigned HSYNC     = VGA_HSYNC,
  parameter int unsigned HBACK     = VGA_HBACK,
  parameter int unsigned VFRONT    = VGA_VFRONT,
  parameter int unsigned VSYNC     = VGA_VSYNC,
  parameter int unsigned VBACK     = VGA_VBACK,
  parameter logic        SYNC_POL  = 1'b0,
  parameter int unsigned NUM_INSTR = 10,
  parameter int unsigned CELL_H    = 10,
  parameter int unsigned TIME_W    = 9
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  input  logic                                 time_run_i,
  input  logic                                 time_mode_i,
  input  logic [2:0]                           time_step_i,
  output logic                                 hsync_o,
  output logic                                 vsync_o,
  output logic                                 blank_o,
  output logic                                 next_line_o,
  output logic                                 next_frame_o,
  output logic                                 execute_o,
  output logic                                 shift_o,
  output logic [$clog2(NUM_INSTR)-1:0]         x_subpos_o,
  output logic [$clog2(WIDTH/NUM_INSTR)-1:0]   x_pos_o,
  output logic [$clog2(HEIGHT/CELL_H)-1:0]     y_pos_o,
  output logic                                 capture_o,
  output logic [TIME_W-1:0]                    time_o
);

  localparam int unsigned HTOTAL = WIDTH + HFRONT + HSYNC + HBACK;
  localparam int unsigned VTOTAL = HEIGHT + VFRONT + VSYNC + VBACK;
  localparam int unsigned H_W    = $clog2(HTOTAL);
  localparam int unsigned V_W    = $clog2(VTOTAL);
  localparam int unsigned XS_W   = $clog2(NUM_INSTR);
  localparam int unsigned XP_W   = $clog2(WIDTH / NUM_INSTR);
  localparam int unsigned YP_W   = $clog2(HEIGHT / CELL_H);
  localparam int unsigned YS_W   = (CELL_H > 1) ? $clog2(CELL_H) : 1;

  localparam logic [H_W-1:0]  H_AHEAD    = H_W'(HTOTAL - NUM_INSTR);
  localparam logic [H_W-1:0]  H_XCLR     = H_W'(HTOTAL - NUM_INSTR - 1);
  localparam logic [H_W-1:0]  H_EXEC_END = H_W'(WIDTH - NUM_INSTR);
  localparam logic [H_W-1:0]  H_YSTEP    = H_W'(WIDTH - NUM_INSTR - 1);
  localparam logic [V_W-1:0]  V_RES      = V_W'(HEIGHT);
  localparam logic [V_W-1:0]  V_YLAST    = V_W'(HEIGHT - 1);
  localparam logic [XS_W-1:0] XS_LAST    = XS_W'(NUM_INSTR - 1);
  localparam logic [YS_W-1:0] YS_LAST    = YS_W'(CELL_H - 1);
  localparam logic [31:0]     TMAX       = 32'((64'd1 << TIME_W) - 64'd1);

  if (WIDTH % NUM_INSTR != 0) begin : g_chk_width
    $error("WIDTH must be a multiple of NUM_INSTR");
  end
  if (HEIGHT % CELL_H != 0) begin : g_chk_height
    $error("HEIGHT must be a multiple of CELL_H");
  end
  if (NUM_INSTR > HBACK + HSYNC + HFRONT) begin : g_chk_instr
    $error("NUM_INSTR must fit inside horizontal blanking");
  end
  if (NUM_INSTR < 2 || TIME_W < 1 || TIME_W > 31) begin : g_chk_range
    $error("NUM_INSTR must be >= 2 and TIME_W within 1..31");
  end

  logic [H_W-1:0]  h_cnt;
  logic [V_W-1:0]  v_cnt;
  logic            h_blank, v_blank, h_last, v_last;
  logic [V_W-1:0]  exec_line;
  logic            h_ahead, exec_active, y_step;
  logic [XS_W-1:0] x_sub_q;
  logic [XP_W-1:0] x_pos_q;
  logic [YS_W-1:0] y_sub_q;
  logic [YP_W-1:0] y_pos_q;
  logic            cap_q;
  logic [TIME_W-1:0] time_q;
  logic            down_q;
  time_next_t      tn;
  logic            time_next_unused;

  raster_axis #(
    .TOTAL      (HTOTAL),
    .RESOLUTION (WIDTH),
    .FRONT      (HFRONT),
    .SYNC       (HSYNC),
    .RESET_VAL  (HTOTAL - NUM_INSTR),
    .SYNC_POL   (SYNC_POL)
  ) u_h_axis (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .enable_i (1'b1),
    .cnt_o    (h_cnt),
    .sync_o   (hsync_o),
    .blank_o  (h_blank),
    .last_o   (h_last)
  );

  raster_axis #(
    .TOTAL      (VTOTAL),
    .RESOLUTION (HEIGHT),
    .FRONT      (VFRONT),
    .SYNC       (VSYNC),
    .RESET_VAL  (VTOTAL - 1),
    .SYNC_POL   (SYNC_POL)
  ) u_v_axis (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .enable_i (h_last),
    .cnt_o    (v_cnt),
    .sync_o   (vsync_o),
    .blank_o  (v_blank),
    .last_o   (v_last)
  );

  // The last NUM_INSTR cycles of a line already execute the first cell of the following line.
  always_comb begin
    h_ahead      = (h_cnt >= H_AHEAD);
    exec_line    = v_cnt;
    if (h_ahead) begin
      exec_line = v_last ? '0 : v_cnt + 1'b1;
    end
    exec_active  = (exec_line < V_RES);
    execute_o    = exec_active && (h_ahead || (h_cnt < H_EXEC_END));
    shift_o      = execute_o || (x_sub_q != '0);
    y_step       = exec_active && (h_cnt == H_YSTEP);
    blank_o      = h_blank | v_blank;
    next_line_o  = h_last;
    next_frame_o = h_last & v_last;
    x_subpos_o   = x_sub_q;
    x_pos_o      = x_pos_q;
    y_pos_o      = y_pos_q;
    capture_o    = cap_q;
    time_o       = time_q;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      x_sub_q <= '0;
      x_pos_q <= '0;
      cap_q   <= 1'b0;
    end else begin
      cap_q <= (x_sub_q == XS_LAST);
      if (shift_o) begin
        x_sub_q <= (x_sub_q == XS_LAST) ? '0 : x_sub_q + 1'b1;
      end
      if (h_cnt == H_XCLR) begin
        x_pos_q <= '0;
      end else if (shift_o && (x_sub_q == XS_LAST)) begin
        x_pos_q <= x_pos_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      y_sub_q <= '0;
      y_pos_q <= '0;
    end else if (y_step) begin
      if (exec_line == V_YLAST) begin
        y_sub_q <= '0;
        y_pos_q <= '0;
      end else if (y_sub_q == YS_LAST) begin
        y_sub_q <= '0;
        y_pos_q <= y_pos_q + 1'b1;
      end else begin
        y_sub_q <= y_sub_q + 1'b1;
      end
    end
  end

  always_comb begin
    tn = time_next(32'(time_q), down_q, time_mode_e'(time_mode_i), time_step_i, TMAX);
    time_next_unused = ^tn.value[31:TIME_W];
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      time_q <= '0;
      down_q <= 1'b0;
    end else if (next_frame_o && time_run_i) begin
      time_q <= tn.value[TIME_W-1:0];
      down_q <= tn.down;
    end
  end

endmodule

// File: tb/tb_shader_raster.sv
module tb_shader_raster;

  // Small timing: HTOTAL=30, VTOTAL=10, frame=300 cycles, 4x2 cells, time max 15.
  localparam int unsigned P_WIDTH = 20;
  localparam int unsigned P_HEIGHT = 6;
  localparam int unsigned P_NI = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_ni, time_run_i, time_mode_i;
  logic [2:0] time_step_i;
  logic       hsync_o, vsync_o, blank_o, next_line_o, next_frame_o;
  logic       execute_o, shift_o, capture_o;
  logic [2:0] x_subpos_o;
  logic [1:0] x_pos_o;
  logic [0:0] y_pos_o;
  logic [3:0] time_o;

  shader_raster #(
    .WIDTH     (P_WIDTH),
    .HEIGHT    (P_HEIGHT),
    .HFRONT    (2),
    .HSYNC     (3),
    .HBACK     (5),
    .VFRONT    (1),
    .VSYNC     (2),
    .VBACK     (1),
    .SYNC_POL  (1'b0),
    .NUM_INSTR (P_NI),
    .CELL_H    (3),
    .TIME_W    (4)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_ni),
    .time_run_i   (time_run_i),
    .time_mode_i  (time_mode_i),
    .time_step_i  (time_step_i),
    .hsync_o      (hsync_o),
    .vsync_o      (vsync_o),
    .blank_o      (blank_o),
    .next_line_o  (next_line_o),
    .next_frame_o (next_frame_o),
    .execute_o    (execute_o),
    .shift_o      (shift_o),
    .x_subpos_o   (x_subpos_o),
    .x_pos_o      (x_pos_o),
    .y_pos_o      (y_pos_o),
    .capture_o    (capture_o),
    .time_o       (time_o)
  );

  int checks = 0;
  int errors = 0;

  function automatic void check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endfunction

  typedef struct {
    logic exe, cap, blank, hs, nl, nf;
    int   sub, xp;
  } cyc_t;

  typedef struct {
    string name;
    int    val;
  } item_t;

  cyc_t  cyc_q[$];
  item_t frame_q[$];
  int    time_q[$];

  // Expected outputs for the 35 cycles following reset release (k=0 is the reset state).
  task automatic push_table();
    string exe_s, cap_s, blk_s, hs_s, nl_s, nf_s, sub_s, xp_s;
    cyc_t c;
    exe_s = "11111111111111111111000000000011111";
    cap_s = "00000100001000010000100000000000000";
    blk_s = "11111000000000000000000001111111111";
    hs_s  = "11111111111111111111111111100011111";
    nl_s  = "00001000000000000000000000000000001";
    nf_s  = "00001000000000000000000000000000000";
    sub_s = "01234012340123401234000000000001234";
    xp_s  = "00000111112222233333000000000000000";
    for (int k = 0; k < 35; k++) begin
      c.exe   = (exe_s[k] == "1");
      c.cap   = (cap_s[k] == "1");
      c.blank = (blk_s[k] == "1");
      c.hs    = (hs_s[k] == "1");
      c.nl    = (nl_s[k] == "1");
      c.nf    = (nf_s[k] == "1");
      c.sub   = int'(sub_s[k]) - 48;
      c.xp    = int'(xp_s[k]) - 48;
      cyc_q.push_back(c);
    end
  endtask

  task automatic push_frame();
    frame_q.push_back('{name: "frame_len",   val: 300});
    frame_q.push_back('{name: "hsync_low",   val: 30});
    frame_q.push_back('{name: "hsync_first", val: 22});
    frame_q.push_back('{name: "hsync_last",  val: 24});
    frame_q.push_back('{name: "vsync_low",   val: 60});
    frame_q.push_back('{name: "vsync_line",  val: 7});
    frame_q.push_back('{name: "blank_cnt",   val: 180});
    frame_q.push_back('{name: "capture_cnt", val: 24});
    frame_q.push_back('{name: "execute_cnt", val: 120});
    frame_q.push_back('{name: "execute_hmax",val: 14});
    frame_q.push_back('{name: "execute_vbl", val: 0});
    frame_q.push_back('{name: "line_cnt",    val: 10});
    frame_q.push_back('{name: "line_gapmin", val: 30});
    frame_q.push_back('{name: "line_gapmax", val: 30});
    frame_q.push_back('{name: "y_pos_code",  val: 224});
  endtask

  // Monitor: pops expectations as the DUT presents cycles / frame ends.
  int   tbl_k, tframe;
  bit   in_frame, nf_prev;
  int   flen, hs_low, hs_first, hs_last, vs_low, vs_line, blank_n, cap_n;
  int   exe_n, exe_hmax, exe_vb, nl_n, gap_min, gap_max, since_nl, y_code;
  cyc_t mc;
  item_t mit;
  int   meas[15];
  int   h;

  function automatic void clear_stats();
    flen = 0; hs_low = 0; hs_first = 1000; hs_last = -1; vs_low = 0; vs_line = -1;
    blank_n = 0; cap_n = 0; exe_n = 0; exe_hmax = -1; exe_vb = 0; nl_n = 0;
    gap_min = 1000; gap_max = 0; since_nl = 0; y_code = 0;
  endfunction

  always @(negedge clk) begin
    if (!rst_ni) begin
      tbl_k    = 0;
      in_frame = 1'b0;
      nf_prev  = 1'b0;
      clear_stats();
    end else begin
      if (cyc_q.size() > 0) begin
        mc = cyc_q.pop_front();
        check($sformatf("execute_o@%0d", tbl_k),   int'(execute_o),   int'(mc.exe));
        check($sformatf("shift_o@%0d", tbl_k),     int'(shift_o),     int'(mc.exe));
        check($sformatf("capture_o@%0d", tbl_k),   int'(capture_o),   int'(mc.cap));
        check($sformatf("blank_o@%0d", tbl_k),     int'(blank_o),     int'(mc.blank));
        check($sformatf("hsync_o@%0d", tbl_k),     int'(hsync_o),     int'(mc.hs));
        check($sformatf("next_line_o@%0d", tbl_k), int'(next_line_o), int'(mc.nl));
        check($sformatf("next_frame_o@%0d", tbl_k),int'(next_frame_o),int'(mc.nf));
        check($sformatf("x_subpos_o@%0d", tbl_k),  int'(x_subpos_o),  mc.sub);
        check($sformatf("x_pos_o@%0d", tbl_k),     int'(x_pos_o),     mc.xp);
        check($sformatf("vsync_o@%0d", tbl_k),     int'(vsync_o),     1);
        check($sformatf("y_pos_o@%0d", tbl_k),     int'(y_pos_o),     0);
        check($sformatf("time_o@%0d", tbl_k),      int'(time_o),      0);
        tbl_k++;
      end
      if (nf_prev && time_q.size() > 0) begin
        check($sformatf("time_o frame %0d", tframe), int'(time_o), time_q.pop_front());
        tframe++;
      end
      if (in_frame) begin
        since_nl++;
        h = since_nl - 1;
        flen++;
        if (!hsync_o) begin
          hs_low++;
          if (h < hs_first) hs_first = h;
          if (h > hs_last) hs_last = h;
        end
        if (!vsync_o) begin
          vs_low++;
          if (vs_line < 0) vs_line = nl_n;
        end
        blank_n += int'(blank_o);
        cap_n   += int'(capture_o);
        if (execute_o) begin
          exe_n++;
          if (h < 25 && h > exe_hmax) exe_hmax = h;
          if (nl_n >= 6 && nl_n <= 8) exe_vb++;
        end
        if (next_line_o) begin
          nl_n++;
          if (since_nl < gap_min) gap_min = since_nl;
          if (since_nl > gap_max) gap_max = since_nl;
          y_code   = (y_code << 1) | int'(y_pos_o);
          since_nl = 0;
        end
        if (next_frame_o) begin
          meas = '{flen, hs_low, hs_first, hs_last, vs_low, vs_line, blank_n, cap_n,
                   exe_n, exe_hmax, exe_vb, nl_n, gap_min, gap_max, y_code};
          for (int i = 0; i < 15; i++) begin
            if (frame_q.size() > 0) begin
              mit = frame_q.pop_front();
              check(mit.name, meas[i], mit.val);
            end
          end
          clear_stats();
        end
      end else if (next_frame_o) begin
        in_frame = 1'b1;
        clear_stats();
      end
      nf_prev = next_frame_o;
    end
  end

  // Apply time controls for one frame end and push the time expected after it.
  task automatic frame(input logic run, input logic mode, input logic [2:0] step, input int exp);
    int n;
    time_run_i  = run;
    time_mode_i = mode;
    time_step_i = step;
    time_q.push_back(exp);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!next_frame_o && n < 400);
    if (!next_frame_o) begin
      checks++;
      errors++;
      $display("FAIL next_frame_o timeout: got 0 after %0d cycles, expected a pulse", n);
    end
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst_ni      = 1'b0;
    time_run_i  = 1'b0;
    time_mode_i = 1'b0;
    time_step_i = 3'd0;
    repeat (3) @(posedge clk);
    #2;
    rst_ni = 1'b1;
    push_table();
    push_frame();
    frame(1'b0, 1'b0, 3'd0, 0);
    frame(1'b0, 1'b0, 3'd0, 0);
    for (int i = 1; i <= 15; i++) frame(1'b1, 1'b0, 3'd1, i);
    for (int i = 16; i <= 30; i++) frame(1'b1, 1'b0, 3'd1, 30 - i);
    frame(1'b1, 1'b0, 3'd1, 1);
    frame(1'b1, 1'b1, 3'd3, 4);
    frame(1'b1, 1'b1, 3'd4, 8);
    frame(1'b1, 1'b1, 3'd4, 12);
    frame(1'b1, 1'b1, 3'd4, 0);
    frame(1'b1, 1'b1, 3'd7, 7);
    frame(1'b1, 1'b1, 3'd6, 13);
    frame(1'b1, 1'b0, 3'd4, 15);
    frame(1'b1, 1'b0, 3'd4, 11);
    frame(1'b0, 1'b0, 3'd4, 11);
    frame(1'b0, 1'b0, 3'd4, 11);
    frame(1'b1, 1'b0, 3'd0, 11);
    repeat (12) @(posedge clk);
    #2;
    rst_ni     = 1'b0;
    time_run_i = 1'b0;
    @(posedge clk);
    #2;
    rst_ni = 1'b1;
    push_table();
    push_frame();
    frame(1'b0, 1'b0, 3'd0, 0);
    frame(1'b0, 1'b0, 3'd0, 0);
    @(negedge clk);
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time exceeded, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/shader_raster.md
Name: shader_raster

Overview:
- Parametrised raster and shader scheduler for the tiny shader pipeline.
- Generates VGA-style H/V timing, the per-cell execute window that runs NUM_INSTR cycles ahead of display, the x/y cell coordinates, the capture strobe and a frame-time counter.
- Generalises the fixed 640x480, 10-instruction scheduler: resolution, porches, sync polarity, cell height and time width are all parameters; the time counter adds a wrap mode, a step size and a run control.
- Feeds shader_memory (shift), shader_execute (execute, positions, time) and the output colour register (capture, blanking).

Parameters:
WIDTH, 640, active pixels per line
HEIGHT, 480, active lines
HFRONT, 16, horizontal front porch
HSYNC, 96, horizontal sync pulse
HBACK, 48, horizontal back porch
VFRONT, 10, vertical front porch
VSYNC, 2, vertical sync pulse
VBACK, 33, vertical back porch
SYNC_POL, 1'b0, level driven during a sync pulse
NUM_INSTR, 10, cycles per cell and cell width in pixels
CELL_H, 10, cell height in lines
TIME_W, 9, time counter width

Ports:
clk_i  in  1  clock
rst_ni  in  1  synchronous active-low reset
time_run_i  in  1  1 = time advances at frame end
time_mode_i  in  1  0 = bounce, 1 = wrap
time_step_i  in  3  time increment per frame
hsync_o  out  1  horizontal sync
vsync_o  out  1  vertical sync
blank_o  out  1  hblank or vblank
next_line_o  out  1  last cycle of a line
next_frame_o  out  1  last cycle of a frame
execute_o  out  1  shader execute window
shift_o  out  1  shader memory shift (execute_o or x_subpos_o != 0)
x_subpos_o  out  clog2(NUM_INSTR)  instruction index in cell
x_pos_o  out  clog2(WIDTH/NUM_INSTR)  cell column
y_pos_o  out  clog2(HEIGHT/CELL_H)  cell row
capture_o  out  1  colour valid to latch
time_o  out  TIME_W  frame time

Behaviour:
- HTOTAL = WIDTH+HFRONT+HSYNC+HBACK; VTOTAL is built the same way. Elaboration error unless WIDTH%NUM_INSTR==0, HEIGHT%CELL_H==0 and NUM_INSTR<=HBACK+HSYNC+HFRONT.
- h_cnt runs 0..HTOTAL-1. v_cnt advances when h_cnt wraps and runs 0..VTOTAL-1. h_cnt 0 / v_cnt 0 is the first displayed pixel.
- Reset state: h_cnt=HTOTAL-NUM_INSTR, v_cnt=VTOTAL-1, all sub-counters 0, time 0, direction up, capture_o 0.
- Reset mid-frame restores this state on the next edge.
- Decode outputs are combinational from registered counters:
  - hsync_o = SYNC_POL when h_cnt is in [WIDTH+HFRONT, WIDTH+HFRONT+HSYNC-1], else ~SYNC_POL. vsync_o is decoded the same way on v_cnt.
  - blank_o = (h_cnt>=WIDTH) | (v_cnt>=HEIGHT).
  - next_line_o = (h_cnt==HTOTAL-1). next_frame_o = next_line_o & (v_cnt==VTOTAL-1).
- exec_line = v_cnt+1 (mod VTOTAL) when h_cnt>=HTOTAL-NUM_INSTR, else v_cnt.
- execute_o = (exec_line<HEIGHT) and (h_cnt>=HTOTAL-NUM_INSTR or h_cnt<WIDTH-NUM_INSTR).
- x_subpos increments while shift_o is high and wraps NUM_INSTR-1 -> 0. It is always 0 when execute_o drops.
- x_pos:
  - increments on each x_subpos wrap.
  - clears at h_cnt==HTOTAL-NUM_INSTR-1.
  - the clear wins over a simultaneous increment.
- y_subpos and y_pos:
  - y_subpos increments on the last execute cycle of a line (h_cnt==WIDTH-NUM_INSTR-1, exec_line<HEIGHT) and wraps CELL_H-1 -> 0.
  - on that wrap, y_pos increments.
  - both clear when that last execute cycle occurs with exec_line==HEIGHT-1.
- capture_o is registered: 1 in the cycle after x_subpos==NUM_INSTR-1, else 0.
- Time: updates only on a next_frame_o cycle with time_run_i=1. Computation is TIME_W+1 bits wide.
  - Wrap mode: time += step, modulo 2^TIME_W.
  - Bounce, direction up: time = min(time+step, max). Direction flips to down when the result equals max.
  - Bounce, direction down: time = max(time-step, 0). Direction flips to up when the result equals 0.
  - time_step_i==0: time holds.
  - Entering wrap mode forces direction up. Mode and step are sampled only at frame end.

Decomposition:
- Package shader_raster_pkg:
  - time_mode_e (TIME_BOUNCE=0, TIME_WRAP=1).
  - default VGA timing localparams.
  - a function computing the next time value and direction.
- Sub-module raster_axis: one counter with TOTAL/RESOLUTION/FRONT/SYNC/RESET_VAL parameters, advancing on enable_i, with sync, blank and last outputs. It is instantiated for H and V.

Test Plan:
- Reset release with defaults:
  - execute_o=1 from cycle 0; x_subpos_o counts 0..9.
  - capture_o=1 at cycle 10; x_pos_o=1 at cycle 10.
  - blank_o=1 for cycles 0..9 and 0 at cycle 10 (h_cnt=0, v_cnt=0).
- Horizontal line:
  - hsync_o=0 for exactly h_cnt 656..751 (96 cycles).
  - execute_o falls after h_cnt 629.
  - 64 capture pulses per active line.
  - next_line_o period is 800 cycles.
- Frame:
  - next_frame_o period is 420000 cycles; vsync_o is low for 1600 cycles.
  - y_pos_o steps every 10 lines and reaches 47.
  - no execute_o during lines 480..523.
- Bounce mode, step 1:
  - time_o reaches 511 after 511 frames, then reads 510 on the next frame.
  - after 511 more frames it reads 0, then 1.
- Wrap and step:
  - wrap mode, step 4, time 508: next frame gives 0.
  - bounce mode, step 4, time 509: 511, then 507.
  - time_run_i=0 holds time across frames.
- Reset asserted mid-line at h_cnt=300: next cycle shows reset state (x_pos 0, time 0, capture 0), and the frame restarts identically to the first scenario.
